// File: rtl/operand_packer_pkg.sv
// Shared matmul constants: default vector geometry and the delivered-pair counter width.
package operand_packer_pkg;
  localparam int NDATA     = 4;
  localparam int NBITS     = 8;
  localparam int VEC_CNT_W = 16;
endpackage

// File: rtl/operand_packer.sv
// Collects Ndata (a,b) element beats into a packed row/column vector pair
// and presents it to the scalar-product stage behind a valid/ready handshake.
module operand_packer
  import operand_packer_pkg::*;
#(
  parameter int Ndata = NDATA,
  parameter int Nbits = NBITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [Nbits-1:0]       in_a,
  input  logic [Nbits-1:0]       in_b,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Nbits*Ndata-1:0] A,
  output logic [Nbits*Ndata-1:0] B,
  output logic [VEC_CNT_W-1:0]   vec_cnt
);

  localparam int W  = Nbits * Ndata;
  localparam int CW = (Ndata > 1) ? $clog2(Ndata) : 1;
  localparam logic [CW-1:0] LAST = CW'(Ndata - 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  asm_a, asm_b;
  logic [W-1:0]  nxt_a, nxt_b;
  logic          last, accept, load, xfer;

  // HOLD is simply "last slot reached while the output is still occupied".
  assign last     = (cnt == LAST);
  assign in_ready = !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign load     = accept && last;
  assign xfer     = out_valid && out_ready;

  always_comb begin
    nxt_a = asm_a;
    nxt_b = asm_b;
    for (int k = 0; k < Ndata; k++) begin
      if (cnt == CW'(k)) begin
        nxt_a[k*Nbits +: Nbits] = in_a;
        nxt_b[k*Nbits +: Nbits] = in_b;
      end
    end
  end

  // Assembly stage: fill counter and partial vectors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      asm_a <= '0;
      asm_b <= '0;
    end else if (flush) begin
      cnt   <= '0;
      asm_a <= '0;
      asm_b <= '0;
    end else if (accept) begin
      if (last) begin
        cnt   <= '0;
        asm_a <= '0;
        asm_b <= '0;
      end else begin
        cnt   <= cnt + CW'(1);
        asm_a <= nxt_a;
        asm_b <= nxt_b;
      end
    end
  end

  // Output stage: completed pair, handed off on out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      vec_cnt   <= '0;
    end else begin
      if (load) begin
        A         <= nxt_a;
        B         <= nxt_b;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (xfer) vec_cnt <= vec_cnt + VEC_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_packer.sv
// Bench for operand_packer: fixed vector table, directed corner sequences,
// and randomized traffic against a queue-based transaction model.
module tb_operand_packer;
  localparam int ND = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [15:0] vec_cnt;

  operand_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .A(A), .B(B), .vec_cnt(vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        v;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        f;
    logic        o;
    logic        rdy;
    logic        ov;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [15:0] vc;
    int          dot;
  } row_t;

  row_t tbl[15];

  // Transaction-level model state
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic        m_ov;
  logic [31:0] m_A;
  logic [31:0] m_B;
  logic [15:0] m_vc;
  logic        exp_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int dot(input logic [31:0] x, input logic [31:0] y);
    int s = 0;
    for (int k = 0; k < ND; k++) s += int'(x[k*8 +: 8]) * int'(y[k*8 +: 8]);
    return s;
  endfunction

  function automatic row_t mk(input logic v, input logic [7:0] a, input logic [7:0] b,
                              input logic f, input logic o, input logic rdy, input logic ov,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [15:0] vc, input int d);
    row_t r;
    r.v = v; r.a = a; r.b = b; r.f = f; r.o = o; r.rdy = rdy; r.ov = ov;
    r.ea = ea; r.eb = eb; r.vc = vc; r.dot = d;
    return r;
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete();
    m_ov = 1'b0; m_A = '0; m_B = '0; m_vc = '0;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic f, input logic o);
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; flush = f; out_ready = o;
    #1;
    exp_rdy = !(qa.size() == ND - 1 && m_ov && !o);
  endtask

  // Applies the rules for one rising edge using the inputs held across it.
  task automatic model_step();
    logic fire, xf, ld;
    fire = in_valid && exp_rdy && !flush;
    xf   = m_ov && out_ready;
    ld   = 1'b0;
    if (flush) begin
      qa.delete(); qb.delete();
    end else if (fire) begin
      qa.push_back(in_a); qb.push_back(in_b);
      if (qa.size() == ND) begin
        for (int k = 0; k < ND; k++) begin
          m_A[k*8 +: 8] = qa[k];
          m_B[k*8 +: 8] = qb[k];
        end
        qa.delete(); qb.delete();
        m_ov = 1'b1;
        ld = 1'b1;
      end
    end
    if (xf) begin
      m_vc = m_vc + 16'd1;
      if (!ld) m_ov = 1'b0;
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic f, input logic o);
    drive(v, a, b, f, o);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("A", 64'(A), 64'(m_A));
    chk("B", 64'(B), 64'(m_B));
    chk("vec_cnt", 64'(vec_cnt), 64'(m_vc));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; flush = 1'b0; out_ready = 1'b0;
    model_reset();

    // Basic pair, then back-pressure with a full second vector queued behind it
    tbl[0]  = mk(H, 8'h01, 8'h05, L, H, H, L, 32'h0, 32'h0, 16'd0, 0);
    tbl[1]  = mk(H, 8'h02, 8'h06, L, H, H, L, 32'h0, 32'h0, 16'd0, 0);
    tbl[2]  = mk(H, 8'h03, 8'h07, L, H, H, L, 32'h0, 32'h0, 16'd0, 0);
    tbl[3]  = mk(H, 8'h04, 8'h08, L, H, H, H, 32'h04030201, 32'h08070605, 16'd0, 70);
    tbl[4]  = mk(L, 8'h00, 8'h00, L, H, H, L, 32'h04030201, 32'h08070605, 16'd1, 0);
    tbl[5]  = mk(H, 8'h11, 8'h21, L, L, H, L, 32'h04030201, 32'h08070605, 16'd1, 0);
    tbl[6]  = mk(H, 8'h12, 8'h22, L, L, H, L, 32'h04030201, 32'h08070605, 16'd1, 0);
    tbl[7]  = mk(H, 8'h13, 8'h23, L, L, H, L, 32'h04030201, 32'h08070605, 16'd1, 0);
    tbl[8]  = mk(H, 8'h14, 8'h24, L, L, H, H, 32'h14131211, 32'h24232221, 16'd1, 2558);
    tbl[9]  = mk(H, 8'h31, 8'h41, L, L, H, H, 32'h14131211, 32'h24232221, 16'd1, 2558);
    tbl[10] = mk(H, 8'h32, 8'h42, L, L, H, H, 32'h14131211, 32'h24232221, 16'd1, 2558);
    tbl[11] = mk(H, 8'h33, 8'h43, L, L, H, H, 32'h14131211, 32'h24232221, 16'd1, 2558);
    tbl[12] = mk(H, 8'h34, 8'h44, L, L, L, H, 32'h14131211, 32'h24232221, 16'd1, 2558);
    tbl[13] = mk(H, 8'h34, 8'h44, L, H, H, H, 32'h34333231, 32'h44434241, 16'd2, 13438);
    tbl[14] = mk(L, 8'h00, 8'h00, L, H, H, L, 32'h34333231, 32'h44434241, 16'd3, 0);

    // Reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_A", 64'(A), 64'(0));
    chk("rst_vec_cnt", 64'(vec_cnt), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].o);
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].rdy));
      @(posedge clk);
      model_step();
      #1;
      chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].ov));
      chk("tbl_A", 64'(A), 64'(tbl[i].ea));
      chk("tbl_B", 64'(B), 64'(tbl[i].eb));
      chk("tbl_vec_cnt", 64'(vec_cnt), 64'(tbl[i].vc));
      if (tbl[i].ov) chk("tbl_dot", 64'(dot(A, B)), 64'(tbl[i].dot));
    end

    // Two back-to-back vectors at full rate
    begin
      logic [15:0] vc0;
      vc0 = m_vc;
      for (int i = 0; i < 2 * ND; i++)
        cyc(H, 8'(8'h60 + i), 8'(8'h70 + i), L, H);
      cyc(L, 8'h00, 8'h00, L, H);
      chk("b2b_vec_cnt", 64'(vec_cnt), 64'(vc0 + 16'd2));
      chk("b2b_A", 64'(A), 64'(32'h67666564));
    end

    // Flush with a simultaneous beat drops both the partial vector and the beat
    cyc(H, 8'h01, 8'h01, L, H);
    cyc(H, 8'h02, 8'h02, L, H);
    cyc(H, 8'hEE, 8'hEE, H, H);
    cyc(H, 8'h09, 8'h19, L, H);
    cyc(H, 8'h0A, 8'h1A, L, H);
    cyc(H, 8'h0B, 8'h1B, L, H);
    cyc(H, 8'h0C, 8'h1C, L, H);
    chk("flush_A", 64'(A), 64'(32'h0C0B0A09));
    chk("flush_B", 64'(B), 64'(32'h1C1B1A19));

    // Asynchronous reset between edges, with a pair pending and 3 beats in flight
    for (int i = 0; i < ND; i++) cyc(H, 8'(8'h40 + i), 8'(8'h48 + i), L, L);
    for (int i = 0; i < 3; i++) cyc(H, 8'(8'h80 + i), 8'(8'h88 + i), L, L);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_A", 64'(A), 64'(0));
    chk("arst_B", 64'(B), 64'(0));
    chk("arst_vec_cnt", 64'(vec_cnt), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    model_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < ND; i++) cyc(H, 8'(8'h51 + i), 8'(8'h61 + i), L, H);
    chk("arst_fresh_A", 64'(A), 64'(32'h54535251));
    chk("arst_fresh_B", 64'(B), 64'(32'h64636261));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, 8'($urandom), 8'($urandom),
          ($urandom % 16) == 0, ($urandom % 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
